// File: rtl/key_scan_pkg.sv
// Shared types and defaults for the push-button debounce block.
package key_pkg;

  localparam int N_KEYS       = 4;
  localparam int DEF_TICK_DIV = 100000;
  localparam int DEF_DB_TICKS = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P_WAIT  = 2'd1,
    PRESSED = 2'd2,
    R_WAIT  = 2'd3
  } key_state_e;

  // Map raw pin levels onto pressed = 1.
  function automatic logic [N_KEYS-1:0] to_pressed(input logic [N_KEYS-1:0] pins,
                                                   input bit active_low);
    return active_low ? ~pins : pins;
  endfunction

endpackage

// File: rtl/key_scan_if.sv
// Key pins and the decoded key events, bundled for the consumer side.
interface key_scan_if;
  import key_pkg::*;

  logic [N_KEYS-1:0] key;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;
  logic [N_KEYS-1:0] toggle;

  modport master (output key, input level, press, rel, toggle);
  modport slave  (input key, output level, press, rel, toggle);

endinterface

// File: rtl/key_debounce_fsm.sv
// Per-key debounce FSM: accepts a new level only after DB_TICKS consecutive ticks.
module key_debounce_fsm
  import key_pkg::*;
#(
  parameter int DB_TICKS = DEF_DB_TICKS
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic toggle
);

  localparam int DBC_W = $clog2(DB_TICKS + 1);
  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_P_WAIT  = P_WAIT;
  localparam logic [1:0] ST_PRESSED = PRESSED;
  localparam logic [1:0] ST_R_WAIT  = R_WAIT;
  localparam logic [DBC_W-1:0] DBC_MAX  = DBC_W'(DB_TICKS);
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_TICKS - 1);

  logic [1:0]       state;
  logic [DBC_W-1:0] dbc;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= ST_IDLE;
      dbc    <= '0;
      press  <= 1'b0;
      rel    <= 1'b0;
      toggle <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (raw) begin
            state <= ST_P_WAIT;
            dbc   <= '0;
          end
        end
        ST_P_WAIT: begin
          // An abort wins over a coincident tick.
          if (!raw) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (dbc != DBC_MAX) dbc <= dbc + 1'b1;
            if (dbc >= DBC_LAST) begin
              state  <= ST_PRESSED;
              press  <= 1'b1;
              toggle <= ~toggle;
            end
          end
        end
        ST_PRESSED: begin
          if (!raw) begin
            state <= ST_R_WAIT;
            dbc   <= '0;
          end
        end
        ST_R_WAIT: begin
          if (raw) begin
            state <= ST_PRESSED;
          end else if (tick) begin
            if (dbc != DBC_MAX) dbc <= dbc + 1'b1;
            if (dbc >= DBC_LAST) begin
              state <= ST_IDLE;
              rel   <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign level = (state == ST_PRESSED) || (state == ST_R_WAIT);

endmodule

// File: rtl/key_scan.sv
// Four-key debounced input: pin synchronisers, polarity fix, shared tick, per-key FSMs.
module key_scan
  import key_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DB_TICKS   = DEF_DB_TICKS,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [N_KEYS-1:0] iKEY,
  output logic [N_KEYS-1:0] oKEY_LEVEL,
  output logic [N_KEYS-1:0] oKEY_PRESS,
  output logic [N_KEYS-1:0] oKEY_RELEASE,
  output logic [N_KEYS-1:0] oKEY_TOGGLE
);

  localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [N_KEYS-1:0] RELEASED_PINS = ACTIVE_LOW ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;
  logic [N_KEYS-1:0] raw;
  logic [TCNT_W-1:0] tick_cnt;
  logic              tick;

  // Synchronisers reset to the released level so no false edge follows reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync_p0 <= RELEASED_PINS;
      sync_p1 <= RELEASED_PINS;
    end else begin
      sync_p0 <= iKEY;
      sync_p1 <= sync_p0;
    end
  end

  assign raw = to_pressed(sync_p1, ACTIVE_LOW);

  // Free-running divider; its wrap cycle is the only tick.
  always_ff @(posedge iCLK) begin
    if (iRST)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TCNT_LAST);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_fsm #(
      .DB_TICKS(DB_TICKS)
    ) u_fsm (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .tick  (tick),
      .raw   (raw[k]),
      .level (oKEY_LEVEL[k]),
      .press (oKEY_PRESS[k]),
      .rel   (oKEY_RELEASE[k]),
      .toggle(oKEY_TOGGLE[k])
    );
  end

endmodule

// File: tb/tb_key_scan.sv
// Scoreboard bench for key_scan with TICK_DIV=4, DB_TICKS=3, active-low pins.
module tb_key_scan;
  import key_pkg::*;

  typedef struct {
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] toggle;
    int         lo;
    int         hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  logic [3:0] exp_toggle = 4'b0000;
  exp_t sb[$];
  exp_t mon_e;

  key_scan_if kif();

  key_scan #(
    .TICK_DIV  (4),
    .DB_TICKS  (3),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iKEY        (kif.key),
    .oKEY_LEVEL  (kif.level),
    .oKEY_PRESS  (kif.press),
    .oKEY_RELEASE(kif.rel),
    .oKEY_TOGGLE (kif.toggle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && ((kif.press | kif.rel) !== 4'b0000)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event cyc=%0d press=%b release=%b", cyc, kif.press, kif.rel);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (kif.press !== mon_e.press || kif.rel !== mon_e.rel || kif.toggle !== mon_e.toggle) begin
          failures++;
          $display("FAIL event_value cyc=%0d got press=%b release=%b toggle=%b want press=%b release=%b toggle=%b",
                   cyc, kif.press, kif.rel, kif.toggle, mon_e.press, mon_e.rel, mon_e.toggle);
        end
        checks++;
        if (cyc < mon_e.lo || cyc > mon_e.hi) begin
          failures++;
          $display("FAIL event_time got cyc=%0d want %0d..%0d", cyc, mon_e.lo, mon_e.hi);
        end
      end
    end
  end

  task automatic drive_key(input logic [3:0] v);
    @(posedge clk);
    #1;
    kif.key = v;
  endtask

  task automatic push_event(input logic [3:0] p, input logic [3:0] r, input int lo_off, input int hi_off);
    exp_t e;
    exp_toggle = exp_toggle ^ p;
    e.press  = p;
    e.rel    = r;
    e.toggle = exp_toggle;
    e.lo     = cyc + lo_off;
    e.hi     = cyc + hi_off;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    kif.key = 4'b1111;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (kif.level !== 4'b0000) begin failures++; $display("FAIL reset_level got=%b want=0000", kif.level); end
    checks++;
    if (kif.press !== 4'b0000) begin failures++; $display("FAIL reset_press got=%b want=0000", kif.press); end
    checks++;
    if (kif.rel !== 4'b0000) begin failures++; $display("FAIL reset_release got=%b want=0000", kif.rel); end
    checks++;
    if (kif.toggle !== 4'b0000) begin failures++; $display("FAIL reset_toggle got=%b want=0000", kif.toggle); end
    rst = 1'b0;
    exp_toggle = 4'b0000;
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (kif.level !== 4'b0000 || kif.toggle !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle got level=%b toggle=%b want 0000/0000", kif.level, kif.toggle);
    end
  endtask

  task automatic test_clean_press;
    drive_key(4'b1110);
    push_event(4'b0001, 4'b0000, 12, 15);
    wait_drain(30);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL clean_press_timeout pending=%0d want=0", sb.size()); sb.delete(); end
    checks++;
    if (kif.level !== 4'b0001) begin failures++; $display("FAIL clean_press_level got=%b want=0001", kif.level); end
    checks++;
    if (kif.toggle !== 4'b0001) begin failures++; $display("FAIL clean_press_toggle got=%b want=0001", kif.toggle); end
  endtask

  task automatic test_bounce;
    logic [3:0] cur;
    cur = 4'b1110;
    for (int i = 0; i < 12; i++) begin
      cur = cur ^ 4'b0010;
      drive_key(cur);
      repeat (4) @(posedge clk);
    end
    drive_key(4'b1100);
    push_event(4'b0010, 4'b0000, 12, 15);
    wait_drain(30);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL bounce_timeout pending=%0d want=0", sb.size()); sb.delete(); end
    checks++;
    if (kif.level !== 4'b0011) begin failures++; $display("FAIL bounce_level got=%b want=0011", kif.level); end
    checks++;
    if (kif.toggle !== 4'b0011) begin failures++; $display("FAIL bounce_toggle got=%b want=0011", kif.toggle); end
  endtask

  task automatic test_release_bounce;
    drive_key(4'b1101);
    repeat (5) @(posedge clk);
    drive_key(4'b1100);
    @(posedge clk);
    drive_key(4'b1101);
    push_event(4'b0000, 4'b0001, 12, 15);
    wait_drain(30);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL release_timeout pending=%0d want=0", sb.size()); sb.delete(); end
    checks++;
    if (kif.level !== 4'b0010) begin failures++; $display("FAIL release_level got=%b want=0010", kif.level); end
    checks++;
    if (kif.toggle !== 4'b0011) begin failures++; $display("FAIL release_toggle got=%b want=0011", kif.toggle); end
  endtask

  task automatic test_simultaneous;
    drive_key(4'b0001);
    push_event(4'b1100, 4'b0000, 12, 15);
    wait_drain(30);
    checks++;
    if (kif.toggle !== 4'b1111) begin failures++; $display("FAIL simul_toggle1 got=%b want=1111", kif.toggle); end
    drive_key(4'b1101);
    push_event(4'b0000, 4'b1100, 12, 15);
    wait_drain(30);
    drive_key(4'b0001);
    push_event(4'b1100, 4'b0000, 12, 15);
    wait_drain(30);
    checks++;
    if (kif.toggle !== 4'b0011) begin failures++; $display("FAIL simul_toggle2 got=%b want=0011", kif.toggle); end
    drive_key(4'b1111);
    push_event(4'b0000, 4'b1110, 12, 15);
    wait_drain(30);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL simul_timeout pending=%0d want=0", sb.size()); sb.delete(); end
    checks++;
    if (kif.level !== 4'b0000) begin failures++; $display("FAIL simul_level got=%b want=0000", kif.level); end
  endtask

  task automatic test_reset_mid;
    drive_key(4'b1110);
    // Two ticks have been counted after 11 cycles; the third cannot have landed yet.
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (kif.press !== 4'b0000 || kif.level !== 4'b0000 || kif.toggle !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_outputs got press=%b level=%b toggle=%b want 0000", kif.press, kif.level, kif.toggle);
    end
    exp_toggle = 4'b0000;
    rst = 1'b0;
    push_event(4'b0001, 4'b0000, 12, 12);
    wait_drain(30);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL midreset_timeout pending=%0d want=0", sb.size()); sb.delete(); end
    checks++;
    if (kif.level !== 4'b0001 || kif.toggle !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_after got level=%b toggle=%b want 0001/0001", kif.level, kif.toggle);
    end
  endtask

  initial begin
    kif.key = 4'b1111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
